pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter PERIOD, default 100, meaning the nominal PWM period in clk cycles; legal range 2..127.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-high reset (name kept per codebase convention; asserted = 1).
REQ-004 SHALL have port pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-005 SHALL have port dc_out  output  7  last measured high time in clk cycles, saturated at 127.
REQ-006 SHALL have port period_out  output  8  last measured period in clk cycles, saturated at 255.
REQ-007 SHALL have port dc_valid  output  1  single-cycle pulse when dc_out/period_out update.
REQ-008 SHALL have port stuck  output  1  high while no pwm_in rising edge is seen within the timeout.

Function
REQ-009 SHALL pass pwm_in through a 2-flop synchronizer; its output is s, and s registered once more is s_d.
REQ-010 SHALL detect a rising edge (rise) in any cycle where s=1 and s_d=0.
REQ-011 SHALL keep per_cnt (8 bit) and hi_cnt (8 bit), both saturating at 255.
REQ-012 On a rise cycle, SHALL load per_cnt<=1 and hi_cnt<=1; otherwise SHALL set per_cnt+=1 and hi_cnt+=s.
REQ-013 SHALL implement states IDLE (reset state), MEASURE and STUCK.
REQ-014 IDLE: on rise, SHALL go to MEASURE without a dc_valid pulse, because the first edge starts a period and does not end one.
REQ-015 MEASURE: on rise, SHALL register dc_out<=min(hi_cnt,127) and period_out<=per_cnt, and pulse dc_valid for exactly 1 cycle, in the cycle after rise.
REQ-016 MEASURE: when per_cnt reaches 2*PERIOD with no rise, SHALL go to STUCK, set stuck=1, dc_out<=(s ? PERIOD : 0) and period_out<=0, and pulse dc_valid once.
REQ-017 STUCK: outputs SHALL hold with no further dc_valid; on rise, SHALL clear stuck, go to MEASURE and give no dc_valid for that edge.
REQ-018 IDLE: timeout SHALL also apply (per_cnt reaches 2*PERIOD), with the same action as REQ-016.
REQ-019 If rise and timeout occur in the same cycle, rise SHALL win.
REQ-020 Latency from pwm_in rising (first sampled by synchronizer flop 1) to dc_valid SHALL be 4 clk cycles.
REQ-021 Periods above 255 cycles cannot occur, because the timeout at 2*PERIOD<=254 fires first.

Reset
REQ-022 rst_n=1 SHALL immediately clear the synchronizer, s_d, per_cnt, hi_cnt, dc_out, period_out, dc_valid and stuck to 0, and force IDLE.
REQ-023 Reset mid-period SHALL discard the partial measurement; the first rise after release SHALL give no dc_valid.

Configuration
REQ-024 With PWM_CAPTURE_GLITCH_FILTER_EN defined, s SHALL be replaced by a 3-sample majority of the synchronizer output; this adds 2 cycles, so REQ-020 latency becomes 6, and 1-cycle pulses/dropouts are rejected.
REQ-025 Without PWM_CAPTURE_GLITCH_FILTER_EN, there SHALL be no filter and no added latency.

Verification
REQ-026 PERIOD=100, pwm_in 30 high/70 low repeating -> from the 2nd rise on, dc_out=30, period_out=100, one dc_valid per 100 cycles, stuck=0.
REQ-027 pwm_in held low after a rise -> 200 cycles after that rise, stuck=1, dc_out=0, period_out=0, exactly one dc_valid.
REQ-028 pwm_in held high after a rise -> stuck=1, dc_out=100, one dc_valid; next rise -> stuck=0 with no dc_valid; the following rise gives a valid measurement.
REQ-029 PERIOD=100, pwm_in 140 high/10 low -> dc_out=127 (saturated), period_out=150.
REQ-030 rst_n pulse 50 cycles into a period -> all outputs 0 asynchronously; first rise after release gives no dc_valid, and the second rise gives correct values.
REQ-031 1-cycle low glitch inside a 30/70 high phase -> with the macro, dc_out=30 unchanged; without it, an extra rise gives a short-period measurement.

Source files
------------

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the high time and period of an asynchronous PWM waveform, in clk
// cycles, and flags a stuck input when no rising edge is seen within twice
// the nominal period.
//
// Optional build macro:
//   PWM_CAPTURE_GLITCH_FILTER_EN - inserts a 3-sample majority filter after
//                                  the synchronizer. It rejects 1-cycle
//                                  pulses/dropouts and adds 2 cycles of latency.
//
// Parameters:
//   PERIOD      nominal PWM period in clk cycles (2..127); timeout is 2*PERIOD
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   rst_n       asynchronous reset, ACTIVE HIGH despite the name
//   pwm_in      asynchronous PWM input
//   dc_out      last measured high time, saturated at 127
//   period_out  last measured period, saturated at 255
//   dc_valid    1-cycle pulse when dc_out/period_out update
//   stuck       high while the input has produced no rising edge in time
//   state_dbg_o current FSM state (0 IDLE, 1 MEASURE, 2 STUCK), debug only
//
// Handshake: dc_valid is a valid-only strobe with no ready. dc_out and
// period_out are stable from the cycle dc_valid is high until the next
// dc_valid pulse, so a consumer may sample them in that cycle or later.
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [6:0] dc_out,
  output logic [7:0] period_out,
  output logic       dc_valid,
  output logic       stuck,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT       = 8'(2 * PERIOD);
  localparam logic [6:0] DC_STUCK_HIGH = 7'(PERIOD);

  // -------------------------------------------------------------------------
  // Input synchronizer
  // -------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic s;
  logic s_dly_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Majority over the last three synchronized samples, registered. Both
  // edges are delayed by the same two cycles, so high time is preserved.
  logic tap1_q;
  logic tap2_q;
  logic maj_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tap1_q <= 1'b0;
      tap2_q <= 1'b0;
      maj_q  <= 1'b0;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      maj_q  <= (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end
  end

  assign s = maj_q;
`else
  assign s = sync2_q;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s_dly_q <= 1'b0;
    end else begin
      s_dly_q <= s;
    end
  end

  logic rise;
  assign rise = s & ~s_dly_q;

  // -------------------------------------------------------------------------
  // Period and high-time counters. The rise cycle itself counts as the first
  // cycle of the new period (and as a high cycle), hence the load of 1.
  // -------------------------------------------------------------------------
  logic [7:0] per_cnt_q, per_cnt_d;
  logic [7:0] hi_cnt_q,  hi_cnt_d;

  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = 8'd1;
      hi_cnt_d  = 8'd1;
    end else begin
      if (per_cnt_q != 8'hFF) per_cnt_d = per_cnt_q + 8'd1;
      if (s && (hi_cnt_q != 8'hFF)) hi_cnt_d = hi_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      per_cnt_q <= 8'd0;
      hi_cnt_q  <= 8'd0;
    end else begin
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
    end
  end

  logic       timeout_hit;
  logic [6:0] hi_sat;
  logic [6:0] dc_stuck_val;

  assign timeout_hit  = (per_cnt_q == TIMEOUT);
  assign hi_sat       = (hi_cnt_q > 8'd127) ? 7'd127 : hi_cnt_q[6:0];
  assign dc_stuck_val = s ? DC_STUCK_HIGH : 7'd0;

  // -------------------------------------------------------------------------
  // Control FSM. Rise is tested before timeout in every state, so a rise in
  // the timeout cycle is treated as a normal period end.
  // -------------------------------------------------------------------------
  state_e     state_q;
  logic [6:0] dc_q;
  logic [7:0] per_q;
  logic       valid_q;
  logic       stuck_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      dc_q    <= 7'd0;
      per_q   <= 8'd0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // First edge only opens a period; nothing to report yet.
          if (rise) begin
            state_q <= ST_MEASURE;
          end else if (timeout_hit) begin
            state_q <= ST_STUCK;
            stuck_q <= 1'b1;
            dc_q    <= dc_stuck_val;
            per_q   <= 8'd0;
            valid_q <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            dc_q    <= hi_sat;
            per_q   <= per_cnt_q;
            valid_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= ST_STUCK;
            stuck_q <= 1'b1;
            dc_q    <= dc_stuck_val;
            per_q   <= 8'd0;
            valid_q <= 1'b1;
          end
        end
        ST_STUCK: begin
          // Recovery edge restarts measurement without reporting.
          if (rise) begin
            state_q <= ST_MEASURE;
            stuck_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register stage: all outputs move together, giving four clocks
  // from the synchronizer's first sampling edge (inclusive) to dc_valid.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dc_out     <= 7'd0;
      period_out <= 8'd0;
      dc_valid   <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      dc_out     <= dc_q;
      period_out <= per_q;
      dc_valid   <= valid_q;
      stuck      <= stuck_q;
    end
  end

  assign state_dbg_o = state_q;

endmodule
